// File: rtl/dtcm_pkg.sv
// Shared types for the dual-port data TCM.
//   dtcm_req_t : one access request (byte address, byte write enables, write data)
//   grant_t    : which requester owns the single array slot this cycle
//   idx_width  : word-index width for a given DEPTH
package dtcm_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wen;
    logic [31:0] wdata;
  } dtcm_req_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_EXT} grant_t;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dtcm_ram.sv
// Single-port DEPTH x 32 byte-writable array with registered read.
// With DTCM_PARITY_EN defined, one even-parity bit per byte is stored alongside
// the data and checked on read; otherwise perr_o is tied low.
//   clk_i   : clock
//   en_i    : access this cycle
//   wen_i   : byte write enables, 0 = read
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read
//   perr_o  : parity mismatch on rdata_o
module dtcm_ram
  import dtcm_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned IdxW = idx_width(DEPTH)
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic [3:0]      wen_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            perr_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (wen_i == 4'b0000) begin
        rdata_q <= mem[idx_i];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wen_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

`ifdef DTCM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic [3:0] rpar_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (wen_i == 4'b0000) begin
        rpar_q <= par[idx_i];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wen_i[b]) par[idx_i][b] <= ^wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    perr_o = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if ((^rdata_q[8*b +: 8]) != rpar_q[b]) perr_o = 1'b1;
    end
  end
`else
  assign perr_o = 1'b0;
`endif

endmodule

// File: rtl/dtcm_dp.sv
// Data TCM with a priority core port and a valid/ready external port sharing
// one single-port array. A starvation counter forces an external slot after
// STARVE_MAX waiting cycles, stalling the core for that cycle.
// Optional macro: DTCM_PARITY_EN (per-byte parity storage and check).
//   core port : c_req, c_addr, c_wen, c_wdata -> c_stall, c_rvalid, c_rdata, c_perr
//   ext port  : x_valid, x_addr, x_wen, x_wdata -> x_ready, x_rvalid, x_rdata, x_perr
module dtcm_dp
  import dtcm_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic [3:0]  c_wen,
  input  logic [31:0] c_wdata,
  output logic        c_stall,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_perr,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [31:0] x_addr,
  input  logic [3:0]  x_wen,
  input  logic [31:0] x_wdata,
  output logic        x_rvalid,
  output logic [31:0] x_rdata,
  output logic        x_perr
);

  localparam int unsigned IdxW = idx_width(DEPTH);
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_q, starve_d;
  logic            force_slot;
  grant_t          grant;
  dtcm_req_t       c_bus, x_bus, sel;
  logic            c_rvalid_q, x_rvalid_q;
  logic [31:0]     c_hold_q, x_hold_q;
  logic [31:0]     ram_rdata;
  logic            ram_perr;

  assign c_bus = '{addr: c_addr, wen: c_wen, wdata: c_wdata};
  assign x_bus = '{addr: x_addr, wen: x_wen, wdata: x_wdata};

  assign force_slot = (starve_q == StarveMax);
  assign x_ready    = x_valid && (!c_req || force_slot);
  assign c_stall    = c_req && force_slot;

  always_comb begin
    grant = GNT_NONE;
    if (x_ready)                   grant = GNT_EXT;
    else if (c_req && !force_slot) grant = GNT_CORE;
  end

  assign sel = (grant == GNT_EXT) ? x_bus : c_bus;

  always_comb begin
    starve_d = starve_q;
    if (!x_valid || x_ready)     starve_d = '0;
    else if (starve_q != StarveMax) starve_d = starve_q + CntW'(1);
  end

  dtcm_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (grant != GNT_NONE),
    .wen_i  (sel.wen),
    .idx_i  (sel.addr[IdxW+1:2]),
    .wdata_i(sel.wdata),
    .rdata_o(ram_rdata),
    .perr_o (ram_perr)
  );

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel.addr[31:IdxW+2], sel.addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= '0;
      c_rvalid_q <= 1'b0;
      x_rvalid_q <= 1'b0;
      c_hold_q   <= '0;
      x_hold_q   <= '0;
    end else begin
      starve_q   <= starve_d;
      c_rvalid_q <= (grant == GNT_CORE) && (sel.wen == 4'b0000);
      x_rvalid_q <= (grant == GNT_EXT) && (sel.wen == 4'b0000);
      // Capture the returned word so rdata holds once rvalid drops.
      if (c_rvalid_q) c_hold_q <= ram_rdata;
      if (x_rvalid_q) x_hold_q <= ram_rdata;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign x_rvalid = x_rvalid_q;
  assign c_rdata  = c_rvalid_q ? ram_rdata : c_hold_q;
  assign x_rdata  = x_rvalid_q ? ram_rdata : x_hold_q;
  assign c_perr   = c_rvalid_q && ram_perr;
  assign x_perr   = x_rvalid_q && ram_perr;

`ifndef SYNTHESIS
  // A waiting external request must be held stable until accepted.
  x_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (x_valid && !x_ready) |=> (x_valid && $stable(x_addr) && $stable(x_wen) && $stable(x_wdata)));
`endif

endmodule

// File: tb/tb_dtcm_dp.sv
module tb_dtcm_dp;

  localparam int unsigned DEPTH      = 1024;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned FLIP_IDX   = 8;
  localparam int unsigned FLIP_BIT   = 16;

  logic        clk, rst_n;
  logic        c_req, c_stall, c_rvalid, c_perr;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_wen;
  logic        x_valid, x_ready, x_rvalid, x_perr;
  logic [31:0] x_addr, x_wdata, x_rdata;
  logic [3:0]  x_wen;

  dtcm_dp #(
    .DEPTH     (DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .c_req   (c_req),
    .c_addr  (c_addr),
    .c_wen   (c_wen),
    .c_wdata (c_wdata),
    .c_stall (c_stall),
    .c_rvalid(c_rvalid),
    .c_rdata (c_rdata),
    .c_perr  (c_perr),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_addr  (x_addr),
    .x_wen   (x_wen),
    .x_wdata (x_wdata),
    .x_rvalid(x_rvalid),
    .x_rdata (x_rdata),
    .x_perr  (x_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [DEPTH];
  logic [3:0]  m_pbad [DEPTH];
  int          m_starve;
  logic        m_crv, m_xrv, m_cpe, m_xpe;
  logic [31:0] m_crd, m_xrd;
  int          flip_cnt = 0;
  int          flip_seen;

  always @(negedge clk) begin : model
    int   ci, xi;
    logic frc, cg, xg, exp_xr, exp_st;
    if (!rst_n) begin
      check("rst_c_rvalid", c_rvalid, 0);
      check("rst_x_rvalid", x_rvalid, 0);
      check("rst_c_rdata",  c_rdata,  0);
      check("rst_x_rdata",  x_rdata,  0);
      check("rst_perr",     {c_perr, x_perr}, 0);
      m_starve  <= 0;
      m_crv     <= 1'b0;
      m_xrv     <= 1'b0;
      m_cpe     <= 1'b0;
      m_xpe     <= 1'b0;
      m_crd     <= '0;
      m_xrd     <= '0;
      flip_seen <= flip_cnt;
      for (int i = 0; i < DEPTH; i++) m_pbad[i] <= 4'b0;
    end else begin
      frc    = (m_starve == STARVE_MAX);
      exp_xr = x_valid && (!c_req || frc);
      exp_st = c_req && frc;
      check("x_ready",  x_ready,  exp_xr);
      check("c_stall",  c_stall,  exp_st);
      check("c_rvalid", c_rvalid, m_crv);
      check("x_rvalid", x_rvalid, m_xrv);
      check("c_rdata",  c_rdata,  m_crd);
      check("x_rdata",  x_rdata,  m_xrd);
`ifdef DTCM_PARITY_EN
      check("c_perr", c_perr, m_crv && m_cpe);
      check("x_perr", x_perr, m_xrv && m_xpe);
`else
      check("c_perr", c_perr, 0);
      check("x_perr", x_perr, 0);
`endif
      // advance one cycle
      ci = int'((c_addr >> 2) % DEPTH);
      xi = int'((x_addr >> 2) % DEPTH);
      cg = c_req && !frc;
      xg = exp_xr;
      m_crv <= cg && (c_wen == 4'b0);
      m_xrv <= xg && (x_wen == 4'b0);
      if (cg && c_wen == 4'b0) begin
        m_crd <= m_mem[ci];
        m_cpe <= |m_pbad[ci];
      end
      if (xg && x_wen == 4'b0) begin
        m_xrd <= m_mem[xi];
        m_xpe <= |m_pbad[xi];
      end
      for (int b = 0; b < 4; b++) begin
        if (cg && c_wen[b]) begin
          m_mem[ci][8*b +: 8] <= c_wdata[8*b +: 8];
          m_pbad[ci][b]       <= 1'b0;
        end
        if (xg && x_wen[b]) begin
          m_mem[xi][8*b +: 8] <= x_wdata[8*b +: 8];
          m_pbad[xi][b]       <= 1'b0;
        end
      end
      if (flip_cnt != flip_seen) begin
        m_mem[FLIP_IDX][FLIP_BIT]      <= ~m_mem[FLIP_IDX][FLIP_BIT];
        m_pbad[FLIP_IDX][FLIP_BIT / 8] <= 1'b1;
        flip_seen                      <= flip_cnt;
      end
      if (!x_valid || xg)            m_starve <= 0;
      else if (m_starve < STARVE_MAX) m_starve <= m_starve + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req = 1'b0; c_addr = '0; c_wen = '0; c_wdata = '0;
    x_valid = 1'b0; x_addr = '0; x_wen = '0; x_wdata = '0;
  endtask

  task automatic core(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    idle();
    c_req = 1'b1; c_addr = a; c_wen = w; c_wdata = d;
  endtask

  task automatic ext(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    idle();
    x_valid = 1'b1; x_addr = a; x_wen = w; x_wdata = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) cyc();
    rst_n = 1'b1;

    // full-word write then read
    core(32'h10, 4'hF, 32'hDEADBEEF); cyc();
    core(32'h10, 4'h0, 32'h0);        cyc();
    idle();
    @(negedge clk);
    check("t1_c_rvalid", c_rvalid, 1);
    check("t1_c_rdata",  c_rdata,  32'hDEADBEEF);
    check("t1_x_rvalid", x_rvalid, 0);
    cyc();

    // partial byte write
    core(32'h10, 4'b0001, 32'h000000AA); cyc();
    core(32'h10, 4'h0, 32'h0);           cyc();
    idle();
    @(negedge clk);
    check("t2_c_rdata", c_rdata, 32'hDEADBEAA);
    cyc();

    // external read with idle core, then aliased address
    core(32'h4, 4'hF, 32'h12345678); cyc();
    ext(32'h4, 4'h0, 32'h0);
    @(negedge clk);
    check("t3_x_ready", x_ready, 1);
    cyc();
    idle();
    @(negedge clk);
    check("t3_x_rvalid", x_rvalid, 1);
    check("t3_x_rdata",  x_rdata,  32'h12345678);
    check("t3_c_rvalid", c_rvalid, 0);
    cyc();
    ext(32'h4 + 4 * DEPTH, 4'h0, 32'h0); cyc();
    idle();
    @(negedge clk);
    check("t3_alias_rdata", x_rdata, 32'h12345678);
    cyc();

    // core read followed by external write to the same word
    core(32'h10, 4'h0, 32'h0);        cyc();
    ext(32'h10, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    check("t4_c_rdata_old", c_rdata, 32'hDEADBEAA);
    cyc();
    core(32'h10, 4'h0, 32'h0); cyc();
    idle();
    @(negedge clk);
    check("t4_c_rdata_new", c_rdata, 32'hCAFEF00D);
    cyc();

    // starvation: external slot forced every STARVE_MAX+1 cycles
    core(32'h10, 4'h0, 32'h0);
    x_valid = 1'b1; x_addr = 32'h4; x_wen = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("t5_x_ready", x_ready, (k % 5) == 0);
      check("t5_c_stall", c_stall, (k % 5) == 0);
      cyc();
    end
    idle(); cyc();

    // reset pulsed the cycle after a granted read
    core(32'h10, 4'h0, 32'h0); cyc();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_c_rvalid_rst", c_rvalid, 0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_c_rvalid_after", c_rvalid, 0);
    check("t6_c_rdata_after",  c_rdata,  0);
    cyc();
    core(32'h10, 4'h0, 32'h0);
    x_valid = 1'b1; x_addr = 32'h4; x_wen = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("t6_x_ready", x_ready, k == 5);
      cyc();
    end
    idle(); cyc();

`ifdef DTCM_PARITY_EN
    core(32'h20, 4'hF, 32'h11223344); cyc();
    idle(); cyc();
    u_dut.u_ram.mem[FLIP_IDX][FLIP_BIT] <= ~u_dut.u_ram.mem[FLIP_IDX][FLIP_BIT];
    flip_cnt++;
    cyc();
    core(32'h20, 4'h0, 32'h0); cyc();
    idle();
    @(negedge clk);
    check("t7_c_rvalid", c_rvalid, 1);
    check("t7_c_perr",   c_perr,   1);
    check("t7_c_rdata",  c_rdata,  32'h11233344);
    cyc();
`endif
    core(32'h10, 4'h0, 32'h0); cyc();
    idle();
    @(negedge clk);
    check("t7_clean_perr", c_perr, 0);
    check("t7_clean_rdata", c_rdata, 32'hCAFEF00D);
    cyc();

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
